// File: rtl/bank_accounter_pkg.sv
// Types and width helpers shared by the bank accounter and the read switch.
package bank_accounter_pkg;

    localparam int MAX_SELECT_RANGE = 2;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    typedef struct packed {
        logic                        flag;
        logic [MAX_SELECT_RANGE-1:0] owner;
    } entry_t;

    function automatic int select_range(input int nb_wragent);
        return (nb_wragent <= 1) ? 1 : $clog2(nb_wragent);
    endfunction

    function automatic int select_width(input int nb_wragent, input int write_collision);
        return select_range(nb_wragent) + write_collision;
    endfunction

endpackage

// File: rtl/bank_accounter_write_arbiter.sv
// Per write agent: owner of its target address this cycle and whether another agent hits it too.
module write_arbiter
    import bank_accounter_pkg::*;
#(
    parameter int  ADDR_WIDTH   = 8,
    parameter int  NB_WRAGENT   = 2,
    localparam int SELECT_RANGE = select_range(NB_WRAGENT)
) (
    input  logic [NB_WRAGENT-1:0]              m_wren,
    input  logic [NB_WRAGENT*ADDR_WIDTH-1:0]   m_wraddr,
    output logic [NB_WRAGENT*SELECT_RANGE-1:0] owner,
    output logic [NB_WRAGENT-1:0]              collision
);

    // Ascending scan: the last matching agent above w is the highest-index writer.
    always_comb begin
        owner     = '0;
        collision = '0;
        for (int unsigned w = 0; w < NB_WRAGENT; w++) begin
            owner[w*SELECT_RANGE +: SELECT_RANGE] = SELECT_RANGE'(w);
            for (int unsigned v = 0; v < NB_WRAGENT; v++) begin
                if (v != w && m_wren[w] && m_wren[v] &&
                    m_wraddr[v*ADDR_WIDTH +: ADDR_WIDTH] == m_wraddr[w*ADDR_WIDTH +: ADDR_WIDTH]) begin
                    collision[w] = 1'b1;
                    if (v > w) begin
                        owner[w*SELECT_RANGE +: SELECT_RANGE] = SELECT_RANGE'(v);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/bank_accounter.sv
// Tracks which bank holds the latest value of each address and drives the read-path bank select.
module bank_accounter
    import bank_accounter_pkg::*;
#(
    parameter int  ADDR_WIDTH      = 8,
    parameter int  NB_WRAGENT      = 2,
    parameter int  NB_RDAGENT      = 2,
    parameter int  WRITE_COLLISION = 1,
    localparam int SELECT_RANGE    = select_range(NB_WRAGENT),
    localparam int SELECT_WIDTH    = select_width(NB_WRAGENT, WRITE_COLLISION)
) (
    input  logic                               aclk,
    input  logic                               srst,
    output logic                               ready,
    input  logic [NB_WRAGENT-1:0]              m_wren,
    input  logic [NB_WRAGENT*ADDR_WIDTH-1:0]   m_wraddr,
    input  logic [NB_RDAGENT-1:0]              m_rden,
    input  logic [NB_RDAGENT*ADDR_WIDTH-1:0]   m_rdaddr,
    output logic [NB_RDAGENT*SELECT_WIDTH-1:0] bank_select,
    output logic [NB_WRAGENT-1:0]              m_wrcollision
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    state_t                             state;
    state_t                             state_next;
    logic [ADDR_WIDTH-1:0]              cnt;
    logic [SELECT_WIDTH-1:0]            entries [DEPTH];
    logic [NB_WRAGENT*SELECT_RANGE-1:0] owner;
    logic [NB_WRAGENT-1:0]              collision;
    logic [SELECT_WIDTH-1:0]            wr_entry [NB_WRAGENT];
    logic                               unused_rden;

    // Lookup does not depend on the read enables.
    assign unused_rden = ^m_rden;

    write_arbiter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NB_WRAGENT (NB_WRAGENT)
    ) u_write_arbiter (
        .m_wren    (m_wren),
        .m_wraddr  (m_wraddr),
        .owner     (owner),
        .collision (collision)
    );

    generate
        if (WRITE_COLLISION != 0) begin : g_flag
            always_comb begin
                for (int unsigned w = 0; w < NB_WRAGENT; w++) begin
                    wr_entry[w] = {collision[w], owner[w*SELECT_RANGE +: SELECT_RANGE]};
                end
            end

            always_ff @(posedge aclk) begin
                if (srst) begin
                    m_wrcollision <= '0;
                end else begin
                    m_wrcollision <= ready ? collision : '0;
                end
            end
        end else begin : g_noflag
            logic unused_collision;
            assign unused_collision = ^collision;

            always_comb begin
                for (int unsigned w = 0; w < NB_WRAGENT; w++) begin
                    wr_entry[w] = owner[w*SELECT_RANGE +: SELECT_RANGE];
                end
            end

            assign m_wrcollision = '0;
        end
    endgenerate

    always_ff @(posedge aclk) begin
        if (srst) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT: if (cnt == '1) state_next = RUN;
            RUN:  state_next = RUN;
        endcase
    end

    // Writers of the same address all carry identical entries, so write order is irrelevant.
    always_ff @(posedge aclk) begin
        if (srst) begin
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            ready <= (state == RUN);
            if (state == INIT) begin
                entries[cnt] <= '0;
                cnt          <= cnt + 1'b1;
            end else if (ready) begin
                for (int unsigned w = 0; w < NB_WRAGENT; w++) begin
                    if (m_wren[w]) begin
                        entries[m_wraddr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_entry[w];
                    end
                end
            end
        end
    end

    always_comb begin
        bank_select = '0;
        if (ready) begin
            for (int unsigned r = 0; r < NB_RDAGENT; r++) begin
                bank_select[r*SELECT_WIDTH +: SELECT_WIDTH] = entries[m_rdaddr[r*ADDR_WIDTH +: ADDR_WIDTH]];
            end
        end
    end

endmodule
